core_bus_arbiter: RTL and testbench
===================================

CORE_BUS_ARBITER -- requirements
Module: core_bus_arbiter

Interface
REQ-001 Parameter RR_ENABLE, default 1; 1 = round-robin on simultaneous requests, 0 = fixed dbus priority.
REQ-002 clk  in  1  core clock.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 ireq  in  ibus_req_t  instruction fetch request (valid, addr[63:0]).
REQ-005 iresp  out  ibus_resp_t  fetch response (addr_ok, data_ok, data[31:0]).
REQ-006 dreq  in  dbus_req_t  data request (valid, addr[63:0], size[2:0], strobe[7:0], data[63:0]).
REQ-007 dresp  out  dbus_resp_t  data response (addr_ok, data_ok, data[63:0]).
REQ-008 mreq_valid  out  1  memory-side request valid.
REQ-009 mreq_is_write  out  1  write request when 1.
REQ-010 mreq_addr  out  64  request byte address.
REQ-011 mreq_size  out  3  log2 access bytes.
REQ-012 mreq_strobe  out  8  byte write enables.
REQ-013 mreq_data  out  64  write data.
REQ-014 mreq_ready  in  1  memory accepts request this cycle.
REQ-015 mresp_valid  in  1  memory response valid (one cycle).
REQ-016 mresp_data  in  64  response data, 8-byte aligned doubleword.

Function
REQ-017 FSM states: IDLE, REQ, WAIT, DONE, plus registered owner (I/D) and last_owner.
REQ-018 IDLE: no valid request -> stay; else grant, latch selected request fields into internal registers, go REQ next cycle.
REQ-019 Grant rule: only one valid -> that one; both valid with RR_ENABLE=1 -> side not equal to last_owner; RR_ENABLE=0 -> dbus.
REQ-020 Requests latched at grant; later changes or deassertion of ireq/dreq do not affect the transaction in flight.
REQ-021 Ibus latched as: mreq_is_write=0, size=3'b010, strobe=0, data=0, addr=ireq.addr.
REQ-022 Dbus latched as: mreq_is_write=|dreq.strobe, size/strobe/data/addr copied unchanged.
REQ-023 REQ: mreq_valid=1 with latched fields held stable; mreq_ready=1 -> WAIT next cycle.
REQ-024 WAIT: mreq_valid=0; mresp_valid=1 -> capture mresp_data, go DONE.
REQ-025 mresp_valid is ignored in IDLE, REQ and DONE.
REQ-026 DONE lasts one cycle: owner's addr_ok=1 and data_ok=1, last_owner<=owner, next state IDLE.
REQ-027 DONE data: dresp.data = captured 64 bits; iresp.data = captured[63:32] if latched addr[2]=1, else captured[31:0].
REQ-028 No new grant is evaluated in DONE; earliest next grant is the following IDLE cycle.
REQ-029 addr_ok/data_ok of the non-owner, and of both sides outside DONE, are 0; response data fields are 0 when data_ok=0.
REQ-030 Best-case latency: request valid in IDLE cycle t, mreq_valid at t+1, mreq_ready at t+1, mresp_valid at t+2, data_ok at t+3.
REQ-031 Only one transaction is outstanding at any time.

Reset
REQ-032 reset=1 at a clock edge: state<=IDLE, last_owner<=I, all latched fields and captured data <=0.
REQ-033 While in reset and in the first cycle after it, mreq_valid, iresp and dresp outputs are all 0.
REQ-034 Reset asserted in REQ or WAIT abandons the transaction; a late mresp_valid arriving in IDLE is ignored.

Verification
REQ-035 Ifetch addr=0x8000_0004, mreq_ready=1 immediately, mresp_data=0x1111_2222_3333_4444 one cycle later -> iresp.data=0x1111_2222, data_ok pulses exactly one cycle, at t+3.
REQ-036 Store addr=0x100, size=3, strobe=0xFF, data=0xDEAD_BEEF_0000_0001 -> mreq_is_write=1 with fields unchanged; mreq_valid held through 3 cycles with mreq_ready=0, then accepted; dresp.data_ok pulses once.
REQ-037 ireq and dreq valid together from reset, RR_ENABLE=1, both held -> grant order D, I, D, I; with RR_ENABLE=0 -> D granted every time.
REQ-038 Load addr=0x208 granted, then dreq.addr changed to 0x300 during WAIT -> mreq_addr stays 0x208 throughout.
REQ-039 reset pulsed during WAIT, then mresp_valid=1 in the next cycle -> no data_ok on either side; state IDLE; the next request completes normally.

Source files
------------

// File: rtl/core_bus_arbiter.sv
// Two-master (instruction fetch / data) to single-memory-port arbiter.
// One transaction in flight: grant and latch, issue, wait for response, return it.
package core_bus_arbiter_pkg;
    localparam int unsigned ADDR_W  = 64;
    localparam int unsigned IDATA_W = 32;
    localparam int unsigned DDATA_W = 64;
    localparam int unsigned SIZE_W  = 3;
    localparam int unsigned STRB_W  = 8;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic               addr_ok;
        logic               data_ok;
        logic [IDATA_W-1:0] data;
    } ibus_resp_t;

    typedef struct packed {
        logic               valid;
        logic [ADDR_W-1:0]  addr;
        logic [SIZE_W-1:0]  size;
        logic [STRB_W-1:0]  strobe;
        logic [DDATA_W-1:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic               addr_ok;
        logic               data_ok;
        logic [DDATA_W-1:0] data;
    } dbus_resp_t;
endpackage

module core_bus_arbiter
    import core_bus_arbiter_pkg::*;
#(
    parameter bit RR_ENABLE = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  ibus_req_t          ireq,
    output ibus_resp_t         iresp,
    input  dbus_req_t          dreq,
    output dbus_resp_t         dresp,
    output logic               mreq_valid,
    output logic               mreq_is_write,
    output logic [ADDR_W-1:0]  mreq_addr,
    output logic [SIZE_W-1:0]  mreq_size,
    output logic [STRB_W-1:0]  mreq_strobe,
    output logic [DDATA_W-1:0] mreq_data,
    input  logic               mreq_ready,
    input  logic               mresp_valid,
    input  logic [DDATA_W-1:0] mresp_data
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    localparam logic [SIZE_W-1:0] IFETCH_SIZE = SIZE_W'(2);

    state_t state;
    owner_t owner;
    owner_t last_owner;

    logic   grant_any_c;
    owner_t grant_c;

    // Grant selection; on contention either alternate away from last owner or favour dbus.
    always_comb begin
        grant_any_c = ireq.valid | dreq.valid;
        grant_c     = OWN_I;
        if (dreq.valid && !ireq.valid) begin
            grant_c = OWN_D;
        end else if (dreq.valid && ireq.valid) begin
            if (!RR_ENABLE || (last_owner == OWN_I)) begin
                grant_c = OWN_D;
            end else begin
                grant_c = OWN_I;
            end
        end
    end

    // Transaction FSM; the mreq_* registers double as the latched request.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            owner         <= OWN_I;
            last_owner    <= OWN_I;
            mreq_valid    <= 1'b0;
            mreq_is_write <= 1'b0;
            mreq_addr     <= '0;
            mreq_size     <= '0;
            mreq_strobe   <= '0;
            mreq_data     <= '0;
            iresp         <= '0;
            dresp         <= '0;
        end else begin
            iresp <= '0;
            dresp <= '0;
            case (state)
                S_IDLE: begin
                    if (grant_any_c) begin
                        owner      <= grant_c;
                        mreq_valid <= 1'b1;
                        state      <= S_REQ;
                        if (grant_c == OWN_D) begin
                            mreq_is_write <= |dreq.strobe;
                            mreq_addr     <= dreq.addr;
                            mreq_size     <= dreq.size;
                            mreq_strobe   <= dreq.strobe;
                            mreq_data     <= dreq.data;
                        end else begin
                            mreq_is_write <= 1'b0;
                            mreq_addr     <= ireq.addr;
                            mreq_size     <= IFETCH_SIZE;
                            mreq_strobe   <= '0;
                            mreq_data     <= '0;
                        end
                    end
                end
                S_REQ: begin
                    if (mreq_ready) begin
                        mreq_valid <= 1'b0;
                        state      <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mresp_valid) begin
                        state <= S_DONE;
                        if (owner == OWN_D) begin
                            dresp.addr_ok <= 1'b1;
                            dresp.data_ok <= 1'b1;
                            dresp.data    <= mresp_data;
                        end else begin
                            iresp.addr_ok <= 1'b1;
                            iresp.data_ok <= 1'b1;
                            iresp.data    <= mreq_addr[2] ? mresp_data[DDATA_W-1:IDATA_W]
                                                          : mresp_data[IDATA_W-1:0];
                        end
                    end
                end
                S_DONE: begin
                    last_owner <= owner;
                    state      <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // A response never goes to both masters, and the request is only offered while issuing.
    a_one_owner: assert property (@(posedge clk) disable iff (reset)
        !(iresp.data_ok && dresp.data_ok));
    a_valid_in_req: assert property (@(posedge clk) disable iff (reset)
        mreq_valid |-> (state == S_REQ));

endmodule

// File: tb/tb_core_bus_arbiter.sv
// Directed bench for core_bus_arbiter: round-robin and fixed-priority instances
// share stimulus and are checked every cycle against a transaction-level model.
module tb_core_bus_arbiter;
    import core_bus_arbiter_pkg::*;

    logic        clk;
    logic        reset;
    ibus_req_t   ireq;
    dbus_req_t   dreq;
    logic        mreq_ready;
    logic        mresp_valid;
    logic [63:0] mresp_data;

    logic        mv_o   [2];
    logic        wr_o   [2];
    logic [63:0] addr_o [2];
    logic [2:0]  size_o [2];
    logic [7:0]  strb_o [2];
    logic [63:0] wdat_o [2];
    ibus_resp_t  iresp_o[2];
    dbus_resp_t  dresp_o[2];

    int n_checks = 0;
    int n_errors = 0;

    core_bus_arbiter #(.RR_ENABLE(1'b1)) u_rr (
        .clk(clk), .reset(reset), .ireq(ireq), .iresp(iresp_o[0]), .dreq(dreq), .dresp(dresp_o[0]),
        .mreq_valid(mv_o[0]), .mreq_is_write(wr_o[0]), .mreq_addr(addr_o[0]), .mreq_size(size_o[0]),
        .mreq_strobe(strb_o[0]), .mreq_data(wdat_o[0]), .mreq_ready(mreq_ready),
        .mresp_valid(mresp_valid), .mresp_data(mresp_data)
    );

    core_bus_arbiter #(.RR_ENABLE(1'b0)) u_fix (
        .clk(clk), .reset(reset), .ireq(ireq), .iresp(iresp_o[1]), .dreq(dreq), .dresp(dresp_o[1]),
        .mreq_valid(mv_o[1]), .mreq_is_write(wr_o[1]), .mreq_addr(addr_o[1]), .mreq_size(size_o[1]),
        .mreq_strobe(strb_o[1]), .mreq_data(wdat_o[1]), .mreq_ready(mreq_ready),
        .mresp_valid(mresp_valid), .mresp_data(mresp_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Transaction-level model: 0 idle, 1 offered to memory, 2 accepted, 3 answered.
    int          m_stage [2] = '{0, 0};
    bit          m_own_d [2] = '{0, 0};
    bit          m_last_d[2] = '{0, 0};
    bit          m_wr    [2] = '{0, 0};
    logic [63:0] m_addr  [2] = '{0, 0};
    logic [2:0]  m_size  [2] = '{0, 0};
    logic [7:0]  m_strb  [2] = '{0, 0};
    logic [63:0] m_wdat  [2] = '{0, 0};
    logic [63:0] m_cap   [2] = '{0, 0};
    bit          gq_rr[$];
    bit          gq_fix[$];

    task automatic model_step(input int k);
        bit d;
        if (reset) begin
            m_stage[k] = 0; m_own_d[k] = 0; m_last_d[k] = 0; m_wr[k] = 0;
            m_addr[k] = '0; m_size[k] = '0; m_strb[k] = '0; m_wdat[k] = '0; m_cap[k] = '0;
        end else if (m_stage[k] == 0) begin
            if (ireq.valid || dreq.valid) begin
                if (ireq.valid && dreq.valid) d = (k == 0) ? !m_last_d[k] : 1'b1;
                else d = dreq.valid;
                m_own_d[k] = d;
                if (k == 0) gq_rr.push_back(d); else gq_fix.push_back(d);
                if (d) begin
                    m_wr[k] = (dreq.strobe != 8'h00); m_addr[k] = dreq.addr; m_size[k] = dreq.size;
                    m_strb[k] = dreq.strobe; m_wdat[k] = dreq.data;
                end else begin
                    m_wr[k] = 1'b0; m_addr[k] = ireq.addr; m_size[k] = 3'd2;
                    m_strb[k] = 8'h00; m_wdat[k] = 64'h0;
                end
                m_stage[k] = 1;
            end
        end else if (m_stage[k] == 1) begin
            if (mreq_ready) m_stage[k] = 2;
        end else if (m_stage[k] == 2) begin
            if (mresp_valid) begin
                m_cap[k] = mresp_data;
                m_stage[k] = 3;
            end
        end else begin
            m_last_d[k] = m_own_d[k];
            m_stage[k] = 0;
        end
    endtask

    task automatic compare_dut(input int k);
        ibus_resp_t ei;
        dbus_resp_t ed;
        ei = '0;
        ed = '0;
        if (m_stage[k] == 3) begin
            if (m_own_d[k]) begin
                ed.addr_ok = 1'b1; ed.data_ok = 1'b1; ed.data = m_cap[k];
            end else begin
                ei.addr_ok = 1'b1; ei.data_ok = 1'b1;
                ei.data = m_addr[k][2] ? m_cap[k][63:32] : m_cap[k][31:0];
            end
        end
        check($sformatf("k%0d_mreq_valid", k), 128'(mv_o[k]), 128'(m_stage[k] == 1));
        if (m_stage[k] == 1) begin
            check($sformatf("k%0d_mreq_fields", k),
                  128'({wr_o[k], size_o[k], strb_o[k], addr_o[k]}),
                  128'({m_wr[k], m_size[k], m_strb[k], m_addr[k]}));
            check($sformatf("k%0d_mreq_data", k), 128'(wdat_o[k]), 128'(m_wdat[k]));
        end
        check($sformatf("k%0d_iresp", k), 128'(iresp_o[k]), 128'(ei));
        check($sformatf("k%0d_dresp", k), 128'(dresp_o[k]), 128'(ed));
    endtask

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) model_step(k);
    end

    always @(posedge clk) begin
        #1;
        for (int k = 0; k < 2; k++) compare_dut(k);
    end

    // Memory responder: optional stall before accept and delay before the response.
    bit          auto_mem = 1'b1;
    int          stall = 0;
    int          resp_delay = 0;
    int          stall_cnt = 0;
    int          resp_cnt = 0;
    logic [63:0] resp_word = 64'h0;

    always @(negedge clk) begin
        if (auto_mem) begin
            mreq_ready  = 1'b0;
            mresp_valid = 1'b0;
            if (reset) begin
                stall_cnt = 0;
                resp_cnt  = 0;
            end else if (resp_cnt > 0) begin
                resp_cnt--;
                if (resp_cnt == 0) begin
                    mresp_valid = 1'b1;
                    mresp_data  = resp_word;
                end
            end else if (mv_o[0]) begin
                if (stall_cnt >= stall) begin
                    mreq_ready = 1'b1;
                    stall_cnt  = 0;
                    resp_cnt   = resp_delay + 1;
                end else begin
                    stall_cnt++;
                end
            end
        end
    end

    initial begin
        int          first;
        int          pulses;
        int          mv_cnt;
        logic [31:0] idat;
        bit          obs_rr[$];
        bit          obs_fix[$];
        bit          exp_rr[4];
        bit          exp_fix[4];

        reset = 1'b1; ireq = '0; dreq = '0;
        mreq_ready = 1'b0; mresp_valid = 1'b0; mresp_data = 64'h0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("rst_mv_k%0d", k), 128'(mv_o[k]), 128'(0));
            check($sformatf("rst_resp_k%0d", k), 128'({iresp_o[k], dresp_o[k]}), 128'(0));
        end
        reset = 1'b0;

        // Instruction fetch at best-case latency, upper word selected by addr[2].
        @(negedge clk);
        ireq.valid = 1'b1; ireq.addr = 64'h8000_0004; resp_word = 64'h1111_2222_3333_4444;
        first = -1; pulses = 0; idat = '0; mv_cnt = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == 1) begin
                ireq.valid = 1'b0;
                check("t1_mv_at_t1", 128'(mv_o[0]), 128'(1));
            end
            if (iresp_o[0].data_ok) begin
                pulses++;
                if (first < 0) begin first = i; idat = iresp_o[0].data; end
            end
        end
        check("t1_pulses", 128'(pulses), 128'(1));
        check("t1_latency", 128'(first), 128'(3));
        check("t1_data", 128'(idat), 128'(32'h1111_2222));

        // Store held 3 cycles without ready.
        dreq.valid = 1'b1; dreq.addr = 64'h100; dreq.size = 3'd3; dreq.strobe = 8'hFF;
        dreq.data = 64'hDEAD_BEEF_0000_0001; stall = 3; resp_word = 64'h0123_4567_89AB_CDEF;
        pulses = 0; mv_cnt = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (i == 1) dreq.valid = 1'b0;
            if (mv_o[0]) begin
                mv_cnt++;
                check("t2_write", 128'({wr_o[0], size_o[0], strb_o[0], addr_o[0], wdat_o[0]}),
                      128'({1'b1, 3'd3, 8'hFF, 64'h100, 64'hDEAD_BEEF_0000_0001}));
            end
            if (dresp_o[0].data_ok) pulses++;
        end
        check("t2_valid_cycles", 128'(mv_cnt), 128'(4));
        check("t2_pulses", 128'(pulses), 128'(1));
        stall = 0;

        // Both masters requesting continuously from reset.
        reset = 1'b1;
        ireq.valid = 1'b1; ireq.addr = 64'h1000;
        dreq.valid = 1'b1; dreq.addr = 64'h40; dreq.size = 3'd3; dreq.strobe = 8'h00; dreq.data = 64'h0;
        resp_word = 64'hA5A5_5A5A_C3C3_3C3C;
        @(negedge clk);
        gq_rr.delete(); gq_fix.delete();
        reset = 1'b0;
        check("t3_first_cycle", 128'({mv_o[0], mv_o[1], iresp_o[0], dresp_o[0], iresp_o[1], dresp_o[1]}), 128'(0));
        for (int i = 1; i <= 24; i++) begin
            @(negedge clk);
            if (iresp_o[0].data_ok) obs_rr.push_back(1'b0);
            if (dresp_o[0].data_ok) obs_rr.push_back(1'b1);
            if (iresp_o[1].data_ok) obs_fix.push_back(1'b0);
            if (dresp_o[1].data_ok) obs_fix.push_back(1'b1);
        end
        ireq.valid = 1'b0; dreq.valid = 1'b0;
        repeat (8) @(negedge clk);
        exp_rr  = '{1'b1, 1'b0, 1'b1, 1'b0};
        exp_fix = '{1'b1, 1'b1, 1'b1, 1'b1};
        check("t3_rr_count", 128'(obs_rr.size() >= 4), 128'(1));
        check("t3_fix_count", 128'(obs_fix.size() >= 4), 128'(1));
        check("t3_model_rr_count", 128'(gq_rr.size() >= 4), 128'(1));
        check("t3_model_fix_count", 128'(gq_fix.size() >= 4), 128'(1));
        for (int j = 0; j < 4; j++) begin
            if (obs_rr.size() > j) check($sformatf("t3_rr_order%0d", j), 128'(obs_rr[j]), 128'(exp_rr[j]));
            if (obs_fix.size() > j) check($sformatf("t3_fix_order%0d", j), 128'(obs_fix[j]), 128'(exp_fix[j]));
            if (gq_rr.size() > j) check($sformatf("t3_model_rr%0d", j), 128'(gq_rr[j]), 128'(exp_rr[j]));
            if (gq_fix.size() > j) check($sformatf("t3_model_fix%0d", j), 128'(gq_fix[j]), 128'(exp_fix[j]));
        end

        // Load whose address changes while the response is pending.
        dreq.valid = 1'b1; dreq.addr = 64'h208; dreq.size = 3'd3; dreq.strobe = 8'h00;
        resp_delay = 3; resp_word = 64'h0BAD_F00D_0000_0208;
        mv_cnt = 0;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            if (i == 1) check("t4_addr_issue", 128'(addr_o[0]), 128'(64'h208));
            if (i == 3) dreq.addr = 64'h300;
            if (i == 6) dreq.valid = 1'b0;
            if (mv_o[0]) mv_cnt++;
            check("t4_addr_hold", 128'(addr_o[0]), 128'(64'h208));
        end
        check("t4_valid_cycles", 128'(mv_cnt), 128'(1));
        resp_delay = 0;

        // Reset during WAIT, then a late response.
        auto_mem = 1'b0; mreq_ready = 1'b0; mresp_valid = 1'b0;
        ireq.valid = 1'b1; ireq.addr = 64'h10;
        @(negedge clk);
        mreq_ready = 1'b1; ireq.valid = 1'b0;
        @(negedge clk);
        mreq_ready = 1'b0; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; mresp_valid = 1'b1; mresp_data = 64'hFFFF_FFFF_FFFF_FFFF;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            mresp_valid = 1'b0;
            for (int k = 0; k < 2; k++)
                check($sformatf("t5_quiet%0d_k%0d", i, k),
                      128'({mv_o[k], iresp_o[k].data_ok, dresp_o[k].data_ok}), 128'(0));
        end
        auto_mem = 1'b1;
        dreq.valid = 1'b1; dreq.addr = 64'h20; dreq.size = 3'd2; dreq.strobe = 8'h0F;
        dreq.data = 64'h0000_0000_CAFE_F00D; resp_word = 64'h7777_8888_9999_AAAA;
        pulses = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == 1) dreq.valid = 1'b0;
            if (dresp_o[0].data_ok) begin
                pulses++;
                check("t5_data", 128'(dresp_o[0].data), 128'(64'h7777_8888_9999_AAAA));
            end
        end
        check("t5_recover", 128'(pulses), 128'(1));

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
